// File: rtl/reg_file_pkg.sv
// Widths, shared types and the clear-sequencer state encoding for the integer register file.
package reg_file_pkg;
    localparam int REG_WIDTH     = 32;
    localparam int RF_ADDR_WIDTH = 5;
    localparam int RF_NUM_REGS   = 2 ** RF_ADDR_WIDTH;

    typedef logic [RF_ADDR_WIDTH-1:0] rf_addr_t;
    typedef logic [REG_WIDTH-1:0]     reg_val_t;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_t;
endpackage

// File: rtl/reg_file_read_port.sv
// One synchronous read port: clear/zero/bypass/array priority mux feeding an enable-gated output register.
module reg_file_read_port
    import reg_file_pkg::*;
#(
    parameter int REG_WIDTH     = reg_file_pkg::REG_WIDTH,
    parameter int RF_ADDR_WIDTH = reg_file_pkg::RF_ADDR_WIDTH,
    parameter bit ZERO_REG_EN   = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_clear,
    input  logic                     ready,
    input  logic                     wr_en,
    input  logic [RF_ADDR_WIDTH-1:0] wr_addr,
    input  logic [REG_WIDTH-1:0]     wr_val,
    input  logic                     rd_en,
    input  logic [RF_ADDR_WIDTH-1:0] rd_addr,
    input  logic [REG_WIDTH-1:0]     arr_val,
    output logic [REG_WIDTH-1:0]     rd_val
);
    logic [REG_WIDTH-1:0] rd_val_q;
    logic [REG_WIDTH-1:0] rd_val_d;

    always_comb begin
        rd_val_d = rd_val_q;
        if (rd_en) begin
            if (in_clear) begin
                rd_val_d = '0;
            end else if (ZERO_REG_EN && (rd_addr == '0)) begin
                rd_val_d = '0;
            end else if (wr_en && ready && (wr_addr == rd_addr)) begin
                // Forward the write landing this same edge so readers never see stale data.
                rd_val_d = wr_val;
            end else begin
                rd_val_d = arr_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_val_q <= '0;
        end else begin
            rd_val_q <= rd_val_d;
        end
    end

    assign rd_val = rd_val_q;
endmodule

// File: rtl/reg_file.sv
// Integer register file: storage, writeback write port, clear-on-reset sequencer and two read ports.
//   state    | meaning
//   RF_CLEAR | sweeping entries to zero, one per cycle; writes dropped, reads return 0
//   RF_RUN   | sweep done, ready high; normal read/write operation
module reg_file
    import reg_file_pkg::*;
#(
    parameter int REG_WIDTH     = reg_file_pkg::REG_WIDTH,
    parameter int RF_ADDR_WIDTH = reg_file_pkg::RF_ADDR_WIDTH,
    parameter bit ZERO_REG_EN   = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rf_wr_en,
    input  logic [RF_ADDR_WIDTH-1:0] rf_wr_addr,
    input  logic [REG_WIDTH-1:0]     rf_wr_val,
    input  logic                     rd0_en,
    input  logic [RF_ADDR_WIDTH-1:0] rd0_addr,
    output logic [REG_WIDTH-1:0]     rd0_val,
    input  logic                     rd1_en,
    input  logic [RF_ADDR_WIDTH-1:0] rd1_addr,
    output logic [REG_WIDTH-1:0]     rd1_val,
    output logic                     ready
);
    localparam int NUM_REGS = 2 ** RF_ADDR_WIDTH;

    rf_state_t                state_q, state_d;
    logic [RF_ADDR_WIDTH-1:0] clr_idx_q, clr_idx_d;
    logic                     ready_q, ready_d;
    logic [REG_WIDTH-1:0]     regs_q [NUM_REGS];
    logic [REG_WIDTH-1:0]     regs_d [NUM_REGS];
    logic                     wr_accept;
    logic                     in_clear;

    assign in_clear  = (state_q == RF_CLEAR);
    assign wr_accept = rf_wr_en && !(ZERO_REG_EN && (rf_wr_addr == '0));

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        ready_d   = ready_q;
        regs_d    = regs_q;
        case (state_q)
            RF_CLEAR: begin
                regs_d[clr_idx_q] = '0;
                clr_idx_d         = clr_idx_q + 1'b1;
                if (clr_idx_q == RF_ADDR_WIDTH'(NUM_REGS - 1)) begin
                    state_d = RF_RUN;
                    ready_d = 1'b1;
                end
            end
            RF_RUN: begin
                if (wr_accept) begin
                    regs_d[rf_wr_addr] = rf_wr_val;
                end
            end
            default: state_d = RF_CLEAR;
        endcase
    end

    // Storage has no reset of its own; the sweep zeroes it after rst falls.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RF_CLEAR;
            clr_idx_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            ready_q   <= ready_d;
            regs_q    <= regs_d;
        end
    end

    assign ready = ready_q;

    reg_file_read_port #(
        .REG_WIDTH     (REG_WIDTH),
        .RF_ADDR_WIDTH (RF_ADDR_WIDTH),
        .ZERO_REG_EN   (ZERO_REG_EN)
    ) u_rd0 (
        .clk      (clk),
        .rst      (rst),
        .in_clear (in_clear),
        .ready    (ready_q),
        .wr_en    (rf_wr_en),
        .wr_addr  (rf_wr_addr),
        .wr_val   (rf_wr_val),
        .rd_en    (rd0_en),
        .rd_addr  (rd0_addr),
        .arr_val  (regs_q[rd0_addr]),
        .rd_val   (rd0_val)
    );

    reg_file_read_port #(
        .REG_WIDTH     (REG_WIDTH),
        .RF_ADDR_WIDTH (RF_ADDR_WIDTH),
        .ZERO_REG_EN   (ZERO_REG_EN)
    ) u_rd1 (
        .clk      (clk),
        .rst      (rst),
        .in_clear (in_clear),
        .ready    (ready_q),
        .wr_en    (rf_wr_en),
        .wr_addr  (rf_wr_addr),
        .wr_val   (rf_wr_val),
        .rd_en    (rd1_en),
        .rd_addr  (rd1_addr),
        .arr_val  (regs_q[rd1_addr]),
        .rd_val   (rd1_val)
    );
endmodule

// File: tb/tb_reg_file.sv
// Directed plus randomized bench for reg_file against an array-based reference model.
module tb_reg_file;
    logic        clk = 1'b0;
    logic        rst;
    logic        rf_wr_en;
    logic [4:0]  rf_wr_addr;
    logic [31:0] rf_wr_val;
    logic        rd0_en;
    logic [4:0]  rd0_addr;
    logic [31:0] rd0_val;
    logic        rd1_en;
    logic [4:0]  rd1_addr;
    logic [31:0] rd1_val;
    logic        ready;

    int checks = 0;
    int errors = 0;
    string cur_tag = "init";

    // Reference model: contents, whether the file is usable, and sweep cycles still to go.
    logic [31:0] mdl [32];
    bit          mdl_run = 1'b0;
    int          sweep_left = 32;
    logic [31:0] exp0 = '0;
    logic [31:0] exp1 = '0;

    always #5 clk = ~clk;

    reg_file dut (
        .clk        (clk),
        .rst        (rst),
        .rf_wr_en   (rf_wr_en),
        .rf_wr_addr (rf_wr_addr),
        .rf_wr_val  (rf_wr_val),
        .rd0_en     (rd0_en),
        .rd0_addr   (rd0_addr),
        .rd0_val    (rd0_val),
        .rd1_en     (rd1_en),
        .rd1_addr   (rd1_addr),
        .rd1_val    (rd1_val),
        .ready      (ready)
    );

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s/%s: observed %h expected %h", cur_tag, name, obs, expv);
        end
    endtask

    function automatic logic [31:0] mdl_read(input logic [4:0] a, input logic we,
                                             input logic [4:0] wa, input logic [31:0] wv);
        if (!mdl_run) return 32'h0;
        if (a == 5'd0) return 32'h0;
        if (we && wa == a) return wv;
        return mdl[a];
    endfunction

    // Apply one cycle of stimulus, advance the model, then check outputs after the edge.
    task automatic cycle(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wv,
                         input logic e0, input logic [4:0] a0, input logic e1, input logic [4:0] a1);
        rst = r; rf_wr_en = we; rf_wr_addr = wa; rf_wr_val = wv;
        rd0_en = e0; rd0_addr = a0; rd1_en = e1; rd1_addr = a1;
        if (r) begin
            exp0 = '0; exp1 = '0;
            mdl_run = 1'b0; sweep_left = 32;
            for (int i = 0; i < 32; i++) mdl[i] = '0;
        end else begin
            if (e0) exp0 = mdl_read(a0, we, wa, wv);
            if (e1) exp1 = mdl_read(a1, we, wa, wv);
            if (mdl_run) begin
                if (we && wa != 5'd0) mdl[wa] = wv;
            end else begin
                sweep_left--;
                if (sweep_left == 0) mdl_run = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        chk("rd0_val", rd0_val, exp0);
        chk("rd1_val", rd1_val, exp1);
        chk("ready", {31'd0, ready}, {31'd0, mdl_run});
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    endtask

    initial begin
        rst = 1'b1; rf_wr_en = 1'b0; rf_wr_addr = '0; rf_wr_val = '0;
        rd0_en = 1'b0; rd0_addr = '0; rd1_en = 1'b0; rd1_addr = '0;

        // Reset sweep: ready low for exactly 32 cycles; a write during clear is dropped.
        cur_tag = "reset";
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        chk("ready_after_rst", {31'd0, ready}, 32'd0);
        cur_tag = "sweep";
        for (int i = 0; i < 32; i++) begin
            if (i == 3) cycle(1'b0, 1'b1, 5'd4, 32'h55, 1'b1, 5'd4, 1'b0, 5'd0);
            else idle();
            if (i < 31) chk("ready_low", {31'd0, ready}, 32'd0);
        end
        chk("ready_high", {31'd0, ready}, 32'd1);
        cur_tag = "read_zero";
        for (int i = 0; i < 32; i++) cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 1'b1, 5'(31 - i));
        cur_tag = "dropped_write";
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 1'b0, 5'd0);
        chk("idx4_zero", rd0_val, 32'h0);

        // Write then read.
        cur_tag = "wr_rd";
        cycle(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 1'b0, 5'd0);
        chk("idx5", rd0_val, 32'hDEADBEEF);

        // Bypass on both ports.
        cur_tag = "bypass";
        cycle(1'b0, 1'b1, 5'd7, 32'h11, 1'b0, 5'd0, 1'b0, 5'd0);
        cycle(1'b0, 1'b1, 5'd7, 32'h22, 1'b1, 5'd7, 1'b1, 5'd7);
        chk("byp0", rd0_val, 32'h22);
        chk("byp1", rd1_val, 32'h22);

        // Zero register, including same-cycle write to index 0.
        cur_tag = "zero_reg";
        cycle(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b1, 5'd0);
        chk("z_byp0", rd0_val, 32'h0);
        chk("z_byp1", rd1_val, 32'h0);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 1'b1, 5'd0);
        chk("z_rd0", rd0_val, 32'h0);

        // Enable hold.
        cur_tag = "hold";
        cycle(1'b0, 1'b1, 5'd3, 32'hAB, 1'b0, 5'd0, 1'b0, 5'd0);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd3);
        chk("rd1_ab", rd1_val, 32'hAB);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd5);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd7);
        chk("rd1_hold", rd1_val, 32'hAB);

        // Mid-RUN reset re-zeroes idx 5, then a reset at sweep cycle 10 restarts the sweep.
        cur_tag = "mid_reset";
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        for (int i = 0; i < 10; i++) idle();
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        for (int i = 0; i < 31; i++) idle();
        chk("ready_still_low", {31'd0, ready}, 32'd0);
        idle();
        chk("ready_restart", {31'd0, ready}, 32'd1);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 1'b1, 5'd3);
        chk("idx5_cleared", rd0_val, 32'h0);

        // Randomized traffic with narrow addresses for frequent bypass and rare resets.
        cur_tag = "random";
        for (int i = 0; i < 400; i++) begin
            logic r;
            r = ($urandom_range(0, 249) == 0);
            cycle(r, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
                  1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
